// File: rtl/seqdet_ctrl.sv
// Word-to-serial feeder with an overlapping pattern detector on the emitted bit stream.
// Counts matches (saturating) and raises a sticky interrupt when the count reaches a threshold.
module seqdet_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_pattern,
  input  logic [2:0]        cfg_len,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              irq_clr,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(WORD_W);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [7:0]         pattern_q, pattern_d;
  logic [2:0]         len_q, len_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [7:0]         hist_q, hist_d;
  logic [3:0]         fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               irq_q, irq_d;
  logic [7:0]         mask;

  assign mask = 8'hFF >> (3'd7 - len_q);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    thresh_d  = thresh_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    count_d   = count_q;
    irq_d     = irq_q;

    if (irq_clr) irq_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          thresh_d  = cfg_thresh;
          hist_d    = '0;
          fill_d    = '0;
          count_d   = '0;
          irq_d     = 1'b0;
        end else if (in_valid) begin
          word_d  = in_data;
          idx_d   = IdxW'(WORD_W - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        word_d = word_q << 1;
        idx_d  = idx_q - 1'b1;
        if (idx_q == '0) state_d = StIdle;
        // Detection runs on the history that already contains the bit emitted this cycle.
        hist_d  = {hist_q[6:0], word_q[WORD_W-1]};
        fill_d  = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
        match_d = (fill_d >= ({1'b0, len_q} + 4'd1)) && (((hist_d ^ pattern_q) & mask) == 8'h00);
        if (match_d && (count_q != '1)) begin
          count_d = count_q + CNT_W'(1);
          if ((thresh_q != '0) && (count_d == thresh_q)) irq_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      idx_q     <= '0;
      pattern_q <= 8'h00;
      len_q     <= 3'd7;
      thresh_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      count_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      thresh_q  <= thresh_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
    end
  end

  assign in_ready    = (state_q == StIdle) && !cfg_we;
  assign bit_valid   = (state_q == StShift);
  assign busy        = (state_q == StShift);
  assign bit_out     = (state_q == StShift) && word_q[WORD_W-1];
  assign match       = match_q;
  assign match_count = count_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Directed bench for seqdet_ctrl: serialisation, overlapping matches, irq and handshake.
module tb_seqdet_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [7:0]        cfg_pattern;
  logic [2:0]        cfg_len;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              irq_clr;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              irq;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seqdet_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .irq_clr     (irq_clr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match       (match),
    .match_count (match_count),
    .irq         (irq),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [2:0] len, input logic [7:0] thr);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_thresh = thr;
    step();
    cfg_we = 1'b0;
  endtask

  // Leaves the bench in cycle T+1 of the accepted word.
  task automatic send(input logic [WORD_W-1:0] w);
    #1;
    check("ready_before_send", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = w;
    step();
    in_valid = 1'b0;
  endtask

  // Index j of each vector holds the value seen in cycle T+1+j.
  task automatic capture(input int n, input int clr_at, output logic [15:0] mv,
                         output logic [15:0] iv, output logic [15:0] vv,
                         output logic [WORD_W-1:0] w);
    mv = '0; iv = '0; vv = '0; w = '0;
    for (int j = 0; j < n; j++) begin
      irq_clr = (j == clr_at);
      mv[j] = match; iv[j] = irq; vv[j] = bit_valid;
      if (bit_valid) w = {w[WORD_W-2:0], bit_out};
      step();
    end
    irq_clr = 1'b0;
  endtask

  logic [15:0]       mv, iv, vv;
  logic [WORD_W-1:0] w;
  int                errs;

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_thresh = 0;
    irq_clr = 0; in_valid = 0; in_data = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_bit_valid", {31'b0, bit_valid}, 32'd0);
    check("rst_bit_out", {31'b0, bit_out}, 32'd0);
    check("rst_match", {31'b0, match}, 32'd0);
    check("rst_count", {24'b0, match_count}, 32'd0);
    check("rst_irq_busy", {30'b0, irq, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    step();

    // 1001 on 0x92: matches on bits 4 and 7 -> pulses T+5, T+8
    cfg(8'h09, 3'd3, 8'd0);
    send(8'h92);
    capture(10, -1, mv, iv, vv, w);
    check("p1001_match", {16'b0, mv}, 32'h090);
    check("p1001_valid", {16'b0, vv}, 32'h0FF);
    check("p1001_bits", {24'b0, w}, 32'h92);
    check("p1001_count", {24'b0, match_count}, 32'd2);

    // 101 on 0xAA: pulses T+4, T+6, T+8
    cfg(8'h05, 3'd2, 8'd0);
    check("cfg_clears_count", {24'b0, match_count}, 32'd0);
    send(8'hAA);
    capture(10, -1, mv, iv, vv, w);
    check("p101_match", {16'b0, mv}, 32'h0A8);
    check("p101_count", {24'b0, match_count}, 32'd3);

    // Cross-word: 0x01 then 0x20 back-to-back
    cfg(8'h09, 3'd3, 8'd0);
    send(8'h01);
    capture(8, -1, mv, iv, vv, w);
    check("xw_first_none", {16'b0, mv}, 32'h0);
    send(8'h20);
    capture(10, -1, mv, iv, vv, w);
    check("xw_match", {16'b0, mv}, 32'h008);
    check("xw_count", {24'b0, match_count}, 32'd1);

    // Threshold 2; irq_clr on the edge that sets irq must lose
    cfg(8'h05, 3'd2, 8'd2);
    send(8'hAA);
    capture(10, 4, mv, iv, vv, w);
    check("irq_rise", {16'b0, iv}, 32'h3E0);
    check("irq_count", {24'b0, match_count}, 32'd3);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // cfg_we beats in_valid; held in_valid is not accepted during SHIFT
    cfg_we = 1'b1; cfg_pattern = 8'h05; cfg_len = 3'd2; cfg_thresh = 8'd0;
    in_valid = 1'b1; in_data = 8'hAA;
    #1;
    check("hs_ready_cfg", {31'b0, in_ready}, 32'd0);
    step();
    cfg_we = 1'b0;
    #1;
    check("hs_ready_after", {31'b0, in_ready}, 32'd1);
    step();
    in_data = 8'h55;
    errs = 0; w = '0;
    for (int k = 1; k <= 8; k++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) errs++;
      w = {w[WORD_W-2:0], bit_out};
      step();
    end
    check("hs_shift_not_ready", errs, 32'd0);
    check("hs_first_word", {24'b0, w}, 32'hAA);
    check("hs_ready_t9", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    capture(10, -1, mv, iv, vv, w);
    check("hs_second_word", {24'b0, w}, 32'h55);
    check("hs_count", {24'b0, match_count}, 32'd6);

    // Asynchronous reset in T+4 during SHIFT
    cfg(8'h05, 3'd2, 8'd0);
    send(8'hAA);
    repeat (3) step();
    check("pre_rst_match", {31'b0, match}, 32'd1);
    check("pre_rst_count", {24'b0, match_count}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_bit_valid", {31'b0, bit_valid}, 32'd0);
    check("arst_match", {31'b0, match}, 32'd0);
    check("arst_count", {24'b0, match_count}, 32'd0);
    check("arst_ready_busy", {30'b0, in_ready, busy}, 32'h2);
    @(negedge clk); reset = 1'b0;
    step();
    send(8'h92);
    capture(10, -1, mv, iv, vv, w);
    check("post_rst_match", {16'b0, mv}, 32'h0);
    check("post_rst_bits", {24'b0, w}, 32'h92);
    check("post_rst_count", {24'b0, match_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
